// File: rtl/core_pkg.sv
// Shared types and constants for the execution control slice.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [XLEN-1:0]  INS_NOP    = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_TRAP
  } state_t;

  function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
    return (opc == OPC_OP_IMM) || (opc == OPC_OP);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: loads the reset vector, advances by one word on inc.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  // Natural 32-bit wrap takes 32'hFFFF_FFFC back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (inc) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with a sticky trap state.
module exec_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   ins,
  output logic              rf_rd_en,
  output logic              alu_en,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_waddr,
  output logic              retire,
  output logic              illegal
);

  state_t state;
  logic   pc_inc;

  assign pc_inc   = (state == ST_WB);
  assign rf_waddr = ins[11:7];

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .inc (pc_inc),
    .pc  (imem_addr)
  );

  // Strobes are set on entry to their state so they mirror the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ins      <= INS_NOP;
      illegal  <= 1'b0;
      imem_req <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      rf_wr_en <= 1'b0;
      retire   <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      rf_wr_en <= 1'b0;
      retire   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!halt) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ins      <= imem_rdata;
            state    <= ST_DECODE;
            rf_rd_en <= 1'b1;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (opc_legal(ins[OPC_W-1:0])) begin
            state  <= ST_EXEC;
            alu_en <= 1'b1;
          end else begin
            state   <= ST_TRAP;
            illegal <= 1'b1;
          end
        end
        ST_EXEC: begin
          state    <= ST_WB;
          rf_wr_en <= (ins[11:7] != REG_AW'(0));
          retire   <= 1'b1;
        end
        ST_WB: begin
          if (halt) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_TRAP: begin
          state <= ST_TRAP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: normal flow, x0 write, fetch wait, halt, trap, resets, PC wrap.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, halt2;
  logic        imem_ack, imem_ack2;
  logic [31:0] imem_rdata, imem_rdata2;

  logic        imem_req, rf_rd_en, alu_en, rf_wr_en, retire, illegal;
  logic [31:0] imem_addr, ins;
  logic [4:0]  rf_waddr;

  logic        imem_req2, rf_rd_en2, alu_en2, rf_wr_en2, retire2, illegal2;
  logic [31:0] imem_addr2, ins2;
  logic [4:0]  rf_waddr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_ctrl dut (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .rf_rd_en(rf_rd_en), .alu_en(alu_en), .rf_wr_en(rf_wr_en),
    .rf_waddr(rf_waddr), .retire(retire), .illegal(illegal)
  );

  exec_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .halt(halt2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .ins(ins2), .rf_rd_en(rf_rd_en2), .alu_en(alu_en2), .rf_wr_en(rf_wr_en2),
    .rf_waddr(rf_waddr2), .retire(retire2), .illegal(illegal2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packs {req, rd, alu, wr, retire, illegal} for compact strobe checks.
  function automatic logic [31:0] strb();
    return 32'({imem_req, rf_rd_en, alu_en, rf_wr_en, retire, illegal});
  endfunction

  initial begin
    rst = 1'b1; halt = 1'b1; halt2 = 1'b1;
    imem_ack = 1'b0; imem_ack2 = 1'b0;
    imem_rdata = 32'h0; imem_rdata2 = 32'h0000_0013;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_strobes", strb(), 32'h00);
    chk("rst_ins", ins, 32'h0000_0013);
    chk("rst_addr", imem_addr, 32'h0);
    step();
    chk("idle_halt", strb(), 32'h00);

    // addi x1,x0,5 with ack already high; ack while IDLE is ignored
    halt = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    chk("addi_fetch", strb(), 32'h20);
    chk("addi_addr", imem_addr, 32'h0);
    chk("ack_idle_ignored", ins, 32'h0000_0013);
    step();
    chk("addi_decode", strb(), 32'h10);
    chk("addi_ins", ins, 32'h0050_0093);
    chk("addi_waddr", 32'(rf_waddr), 32'd1);
    step();
    chk("addi_exec", strb(), 32'h08);
    step();
    chk("addi_wb", strb(), 32'h06);
    imem_rdata = 32'h0020_8033;
    step();
    chk("add_fetch", strb(), 32'h20);
    chk("pc_plus4", imem_addr, 32'h4);

    // add x0,x1,x2: retires without a register write
    step();
    chk("add_decode", strb(), 32'h10);
    chk("add_waddr", 32'(rf_waddr), 32'd0);
    step();
    chk("add_exec", strb(), 32'h08);
    imem_ack = 1'b0;
    step();
    chk("add_wb_x0", strb(), 32'h02);

    // Acknowledge delayed by three cycles
    step();
    chk("wait_f1", strb(), 32'h20);
    chk("wait_a1", imem_addr, 32'h8);
    imem_rdata = 32'h0000_0003;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", strb(), 32'h20);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_ins_hold", ins, 32'h0020_8033);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0010_0193;
    step();
    chk("wait_decode", strb(), 32'h10);
    step();
    step();
    chk("wait_wb", strb(), 32'h06);
    chk("wait_waddr", 32'(rf_waddr), 32'd3);
    step();
    chk("wait_latency7", strb(), 32'h20);
    chk("wait_next_addr", imem_addr, 32'hC);

    // halt raised during EXEC does not abort the instruction
    imem_rdata = 32'h0010_0213;
    step();
    step();
    chk("halt_exec", strb(), 32'h08);
    halt = 1'b1;
    step();
    chk("halt_wb", strb(), 32'h06);
    step();
    chk("halt_idle", strb(), 32'h00);
    chk("halt_idle_addr", imem_addr, 32'h10);
    step();
    chk("halt_idle2", strb(), 32'h00);
    halt = 1'b0; imem_rdata = 32'h0000_0003;
    step();
    chk("resume_fetch", strb(), 32'h20);
    chk("resume_addr", imem_addr, 32'h10);

    // Unsupported opcode traps until reset
    step();
    chk("trap_decode", strb(), 32'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trap_hold", strb(), 32'h01);
      chk("trap_pc", imem_addr, 32'h10);
    end
    rst = 1'b1;
    step();
    chk("trap_rst", strb(), 32'h00);
    chk("trap_rst_ins", ins, 32'h0000_0013);
    chk("trap_rst_pc", imem_addr, 32'h0);

    // Reset while fetching wins over a simultaneous ack
    rst = 1'b0; imem_ack = 1'b0;
    step();
    chk("rf_fetch", strb(), 32'h20);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    chk("rf_req_drop", strb(), 32'h00);
    chk("rf_ins_nop", ins, 32'h0000_0013);
    rst = 1'b0; halt = 1'b1;

    // PC wrap from 32'hFFFF_FFFC
    chk("wrap_rst_addr", imem_addr2, 32'hFFFF_FFFC);
    halt2 = 1'b0; imem_ack2 = 1'b1;
    step();
    chk("wrap_fetch", 32'(imem_req2), 32'd1);
    step(); step(); step();
    chk("wrap_retire", 32'(retire2), 32'd1);
    step();
    chk("wrap_addr", imem_addr2, 32'h0);
    chk("wrap_req", 32'(imem_req2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, program counter value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 halt  input  1  when high, blocks issue of a new instruction fetch.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  32  fetch address; always equals current PC.
REQ-007 imem_ack  input  1  fetch completion strobe; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 ins  output  32  latched instruction register, driven to the decoder.
REQ-010 rf_rd_en  output  1  register-file read strobe for rs1/rs2.
REQ-011 alu_en  output  1  ALU operate strobe.
REQ-012 rf_wr_en  output  1  register-file write strobe.
REQ-013 rf_waddr  output  5  write destination, equal to ins[11:7].
REQ-014 retire  output  1  one-cycle pulse per completed instruction.
REQ-015 illegal  output  1  sticky flag: unsupported opcode encountered.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB and TRAP.
REQ-017 IDLE: when halt=0, go to FETCH; when halt=1, remain in IDLE.
REQ-018 FETCH: imem_req=1 with imem_addr=PC, held stable until imem_ack=1.
REQ-019 On imem_ack in FETCH, ins SHALL load imem_rdata and the FSM SHALL go to DECODE next cycle.
REQ-020 imem_ack outside FETCH SHALL be ignored; ins SHALL not change.
REQ-021 DECODE: rf_rd_en=1 for exactly one cycle.
REQ-022 In DECODE, if ins[6:0] is 7'b0010011 (OP-IMM) or 7'b0110011 (OP), go to EXEC; otherwise go to TRAP.
REQ-023 EXEC: alu_en=1 for exactly one cycle, then go to WB.
REQ-024 WB: rf_wr_en=1 only when ins[11:7]!=0 (x0 writes suppressed); retire=1 in all cases.
REQ-025 WB: PC SHALL become PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-026 From WB, go to FETCH if halt=0, else to IDLE.
REQ-027 halt SHALL NOT abort an instruction already in FETCH..WB.
REQ-028 TRAP: illegal=1; all strobes 0; PC unchanged; FSM remains in TRAP until rst.
REQ-029 Strobes rf_rd_en, alu_en, rf_wr_en and retire SHALL be mutually exclusive and decoded from the state register (Moore outputs).
REQ-030 With zero-wait acknowledge, each instruction SHALL take exactly 4 cycles (FETCH, DECODE, EXEC, WB); each wait cycle adds one cycle in FETCH.
REQ-031 rf_waddr SHALL equal ins[11:7] continuously.

Reset
REQ-032 When rst is high at a clock edge, the next cycle SHALL have: state=IDLE, PC=RESET_PC, ins=32'h0000_0013 (NOP), illegal=0, and all strobes=0.
REQ-033 rst SHALL take priority over every transition, including a simultaneous imem_ack and exit from TRAP.
REQ-034 Reset during FETCH SHALL drop imem_req in the next cycle; the in-flight fetch is abandoned.

Structure
REQ-035 A shared package core_pkg SHALL hold the state typedef, OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011 and the NOP encoding.
REQ-036 A single sub-module pc_reg (reset value, increment-by-4 enable) is natural; legality check stays inline.
REQ-037 The decoder SHALL be instantiated outside this block and fed from ins.

Verification
REQ-038 Sequence: reset, then addi x1,x0,5 (32'h0050_0093) with ack in the same cycle as request. Required: imem_addr=0; strobes in order rd, alu, wr over cycles 2-4; rf_waddr=1; retire pulse; PC=4.
REQ-039 add x0,x1,x2 (32'h0020_8033). Required: retire=1, rf_wr_en stays 0.
REQ-040 Acknowledge delayed 3 cycles. Required: imem_req and imem_addr stable for 4 cycles; instruction latency 7 cycles.
REQ-041 Fetch 32'h0000_0003 (load opcode). Required: TRAP with illegal=1 held; no alu_en, rf_wr_en or retire; PC unchanged; rst clears illegal.
REQ-042 RESET_PC=32'hFFFF_FFFC, execute one NOP. Required: next imem_addr=32'h0000_0000.
REQ-043 Assert halt during EXEC. Required: the instruction completes, retire pulses, FSM enters IDLE with imem_req=0; deasserting halt resumes FETCH.
